// File: rtl/lab3_mem_refill_port_arbiter_if.sv
// Bundle of the two cache memreq/memresp ports, the shared memory port and busy.
// master: the arbiter's view. slave: the caches and memory around it.
interface lab3_mem_refill_port_arbiter_if #(
    parameter int p_req_nbits  = 175,
    parameter int p_resp_nbits = 145
);
    logic                    req0_val;
    logic                    req0_rdy;
    logic [p_req_nbits-1:0]  req0_msg;
    logic                    resp0_val;
    logic                    resp0_rdy;
    logic [p_resp_nbits-1:0] resp0_msg;

    logic                    req1_val;
    logic                    req1_rdy;
    logic [p_req_nbits-1:0]  req1_msg;
    logic                    resp1_val;
    logic                    resp1_rdy;
    logic [p_resp_nbits-1:0] resp1_msg;

    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [p_req_nbits-1:0]  memreq_msg;
    logic                    memresp_val;
    logic                    memresp_rdy;
    logic [p_resp_nbits-1:0] memresp_msg;

    logic                    busy;

    modport master (
        input  req0_val, req0_msg, resp0_rdy,
        input  req1_val, req1_msg, resp1_rdy,
        input  memreq_rdy, memresp_val, memresp_msg,
        output req0_rdy, resp0_val, resp0_msg,
        output req1_rdy, resp1_val, resp1_msg,
        output memreq_val, memreq_msg, memresp_rdy,
        output busy
    );

    modport slave (
        output req0_val, req0_msg, resp0_rdy,
        output req1_val, req1_msg, resp1_rdy,
        output memreq_rdy, memresp_val, memresp_msg,
        input  req0_rdy, resp0_val, resp0_msg,
        input  req1_rdy, resp1_val, resp1_msg,
        input  memreq_val, memreq_msg, memresp_rdy,
        input  busy
    );
endinterface

// File: rtl/lab3_mem_refill_port_arbiter.sv
// Shares one memory port between the instruction cache (requester 0) and the
// data cache (requester 1). One transaction in flight, round-robin on contention,
// the single response is routed back to whoever issued the request.
module lab3_mem_refill_port_arbiter #(
    parameter int p_req_nbits  = 175,
    parameter int p_resp_nbits = 145
) (
    input  logic clk,
    input  logic reset,
    lab3_mem_refill_port_arbiter_if.master bus
);

    // state | meaning
    // IDLE  | no transaction, arbitrating between the two caches
    // SEND  | presenting req_reg to memory until it is accepted
    // WAIT  | memresp_rdy high, waiting for the single response
    // RESP  | presenting resp_reg to the owner until it is accepted
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state;
    logic                    owner;
    logic                    last_grant;
    logic [p_req_nbits-1:0]  req_reg;
    logic [p_resp_nbits-1:0] resp_reg;

    logic in_idle;
    logic in_send;
    logic in_wait;
    logic in_resp;
    logic any_req;
    logic grant;
    logic req_fire;
    logic resp_fire;

    // State decode; every handshake output is held low while reset is asserted.
    always_comb begin
        in_idle = 1'b0;
        in_send = 1'b0;
        in_wait = 1'b0;
        in_resp = 1'b0;
        if (reset) begin
            case (state)
                IDLE:    in_idle = 1'b1;
                SEND:    in_send = 1'b1;
                WAIT:    in_wait = 1'b1;
                RESP:    in_resp = 1'b1;
                default: ;
            endcase
        end
    end

    // Round-robin pick: a lone requester wins, on contention the one not served last.
    always_comb begin
        any_req   = bus.req0_val | bus.req1_val;
        grant     = (bus.req0_val & bus.req1_val) ? ~last_grant : bus.req1_val;
        req_fire  = in_idle & any_req;
        resp_fire = in_resp & (owner ? bus.resp1_rdy : bus.resp0_rdy);
    end

    assign bus.req0_rdy    = req_fire & ~grant;
    assign bus.req1_rdy    = req_fire & grant;
    assign bus.memreq_val  = in_send;
    assign bus.memreq_msg  = req_reg;
    assign bus.memresp_rdy = in_wait;
    assign bus.resp0_val   = in_resp & ~owner;
    assign bus.resp1_val   = in_resp & owner;
    assign bus.resp0_msg   = resp_reg;
    assign bus.resp1_msg   = resp_reg;
    assign bus.busy        = in_send | in_wait | in_resp;

    // Transaction sequencing and fairness bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (bus.memreq_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (bus.memresp_val) state <= RESP;
                end
                RESP: begin
                    if (resp_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Message holding registers; contents are meaningless outside their state.
    always_ff @(posedge clk) begin
        if (req_fire) req_reg <= grant ? bus.req1_msg : bus.req0_msg;
        if (in_wait && bus.memresp_val) resp_reg <= bus.memresp_msg;
    end

    // Memory may only answer while a response is being waited for.
    memresp_only_in_wait: assert property (
        @(posedge clk) disable iff (!reset) bus.memresp_val |-> (state == WAIT)
    );

endmodule

// File: tb/tb_lab3_mem_refill_port_arbiter.sv
// Directed bench for lab3_mem_refill_port_arbiter: two cache sources, two
// response sinks and a small memory model around the DUT. Inputs change 1ns
// after the rising edge, outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_lab3_mem_refill_port_arbiter;

    localparam int RQ = 175;
    localparam int RS = 145;

    typedef logic [RQ-1:0] req_t;
    typedef logic [RS-1:0] resp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lab3_mem_refill_port_arbiter_if #(.p_req_nbits(RQ), .p_resp_nbits(RS)) bus_if ();

    lab3_mem_refill_port_arbiter #(.p_req_nbits(RQ), .p_resp_nbits(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    req_t  src0_q[$];
    req_t  src1_q[$];
    req_t  mem_log[$];
    resp_t got0[$];
    resp_t got1[$];
    int    resp_order[$];

    bit   f_req0, f_req1, f_memreq, f_memresp, f_resp0, f_resp1;
    bit   s_memreq_val, s_resp0_val, s_resp1_val;
    req_t s_memreq_msg;

    bit   mem_rand = 1'b0;
    bit   sink_rand = 1'b0;
    int   mem_lat = 0;
    int   mreq_stall = 0;
    int   sink_cnt0 = 0;
    int   sink_cnt1 = 0;
    bit   mem_busy = 1'b0;
    int   mem_hold = 0;
    req_t mem_cur = '0;

    function automatic req_t make_req(input logic [2:0] typ, input logic [7:0] opq,
                                      input logic [31:0] addr, input logic [127:0] data);
        return {typ, opq, addr, 4'd0, data};
    endfunction

    // Memory answer: echoes type/opaque/len, low data word is addr ^ 0xDEADAEEF.
    function automatic resp_t mem_resp(input req_t q);
        return {q[174:172], q[171:164], 2'b00, q[131:128], q[127:32], q[163:132] ^ 32'hDEAD_AEEF};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: what is visible now is what the next rising edge samples.
    always @(negedge clk) begin
        f_req0       = bus_if.req0_val && bus_if.req0_rdy;
        f_req1       = bus_if.req1_val && bus_if.req1_rdy;
        f_memreq     = bus_if.memreq_val && bus_if.memreq_rdy;
        f_memresp    = bus_if.memresp_val && bus_if.memresp_rdy;
        f_resp0      = bus_if.resp0_val && bus_if.resp0_rdy;
        f_resp1      = bus_if.resp1_val && bus_if.resp1_rdy;
        s_memreq_val = bus_if.memreq_val;
        s_memreq_msg = bus_if.memreq_msg;
        s_resp0_val  = bus_if.resp0_val;
        s_resp1_val  = bus_if.resp1_val;
        if (f_memreq) mem_log.push_back(bus_if.memreq_msg);
        if (f_resp0) begin got0.push_back(bus_if.resp0_msg); resp_order.push_back(0); end
        if (f_resp1) begin got1.push_back(bus_if.resp1_msg); resp_order.push_back(1); end
    end

    // Requester 0 source.
    always @(posedge clk) begin
        #1;
        if (f_req0 && src0_q.size() > 0) void'(src0_q.pop_front());
        bus_if.req0_val = (src0_q.size() > 0);
        bus_if.req0_msg = (src0_q.size() > 0) ? src0_q[0] : '0;
    end

    // Requester 1 source.
    always @(posedge clk) begin
        #1;
        if (f_req1 && src1_q.size() > 0) void'(src1_q.pop_front());
        bus_if.req1_val = (src1_q.size() > 0);
        bus_if.req1_msg = (src1_q.size() > 0) ? src1_q[0] : '0;
    end

    // Requester 0 sink: holds rdy low for sink_cnt0 cycles of a pending response.
    always @(posedge clk) begin
        #1;
        if (!reset) sink_cnt0 = 0;
        else if (f_resp0) sink_cnt0 = sink_rand ? int'($urandom_range(0, 4)) : 0;
        else if (s_resp0_val && sink_cnt0 > 0) sink_cnt0--;
        bus_if.resp0_rdy = (sink_cnt0 == 0);
    end

    // Requester 1 sink.
    always @(posedge clk) begin
        #1;
        if (!reset) sink_cnt1 = 0;
        else if (f_resp1) sink_cnt1 = sink_rand ? int'($urandom_range(0, 4)) : 0;
        else if (s_resp1_val && sink_cnt1 > 0) sink_cnt1--;
        bus_if.resp1_rdy = (sink_cnt1 == 0);
    end

    // Memory model: optional request stall, then answer after mem_hold cycles.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            mem_busy   = 1'b0;
            mreq_stall = 0;
        end else begin
            if (f_memresp) mem_busy = 1'b0;
            if (f_memreq) begin
                mem_busy = 1'b1;
                mem_cur  = s_memreq_msg;
                mem_hold = mem_rand ? int'($urandom_range(0, 10)) : mem_lat;
                if (mem_rand) mreq_stall = int'($urandom_range(0, 2));
            end else if (s_memreq_val && mreq_stall > 0) begin
                mreq_stall--;
            end else if (mem_busy && mem_hold > 0) begin
                mem_hold--;
            end
        end
        bus_if.memreq_rdy  = !mem_busy && (mreq_stall == 0);
        bus_if.memresp_val = mem_busy && (mem_hold == 0);
        bus_if.memresp_msg = mem_resp(mem_cur);
    end

    task automatic clear_logs();
        mem_log.delete();
        got0.delete();
        got1.delete();
        resp_order.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        obs = {bus_if.busy, bus_if.memreq_val, bus_if.memresp_rdy, bus_if.resp0_val,
               bus_if.resp1_val, bus_if.req0_rdy, bus_if.req1_rdy};
        checks++;
        if (obs !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000000", obs);
        end
        src0_q.push_back(make_req(3'd0, 8'h01, 32'h0000_0040, '0));
        @(negedge clk);
        checks++;
        if (bus_if.req0_val !== 1'b1 || bus_if.req0_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_gates_rdy: val=%b rdy=%b expected val=1 rdy=0",
                     bus_if.req0_val, bus_if.req0_rdy);
        end
        src0_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        obs = {bus_if.busy, bus_if.memreq_val, bus_if.memresp_rdy, bus_if.resp0_val,
               bus_if.resp1_val, bus_if.req0_rdy, bus_if.req1_rdy};
        checks++;
        if (obs !== 7'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 0000000", obs);
        end
    endtask

    task automatic test_single();
        req_t  rq;
        resp_t ex;
        int    t_acc = -1, t_mv = -1, t_mr = -1, t_rv = -1;
        bit    r1 = 1'b0, done = 1'b0;
        rq = make_req(3'd0, 8'h05, 32'h0000_1000, '0);
        ex = mem_resp(rq);
        clear_logs();
        src0_q.push_back(rq);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus_if.req0_val && bus_if.req0_rdy) t_acc = cyc;
            if (bus_if.memreq_val && t_mv < 0) t_mv = cyc;
            if (bus_if.memresp_val && bus_if.memresp_rdy) t_mr = cyc;
            if (bus_if.resp0_val && t_rv < 0) t_rv = cyc;
            if (bus_if.resp1_val) r1 = 1'b1;
            if (bus_if.resp0_val && bus_if.resp0_rdy) done = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!done) begin errors++; $display("FAIL single_timeout: no resp0 handshake in 40 cycles"); end
        checks++;
        if (t_mv != t_acc + 1) begin
            errors++; $display("FAIL single_req_latency: memreq_val at %0d expected %0d", t_mv, t_acc + 1);
        end
        checks++;
        if (t_rv != t_mr + 1) begin
            errors++; $display("FAIL single_resp_latency: resp0_val at %0d expected %0d", t_rv, t_mr + 1);
        end
        checks++;
        if (t_rv != t_acc + 3) begin
            errors++; $display("FAIL single_occupancy: resp0_val at %0d expected %0d", t_rv, t_acc + 3);
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== ex) begin
            errors++; $display("FAIL single_msg: got %0d resp(s), first %h expected %h",
                               got0.size(), (got0.size() > 0) ? got0[0] : resp_t'('0), ex);
        end else begin
            checks++;
            if (got0[0][141:134] !== 8'h05 || got0[0][31:0] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL single_fields: opaque %h data %h expected 05 deadbeef",
                                   got0[0][141:134], got0[0][31:0]);
            end
        end
        checks++;
        if (r1) begin errors++; $display("FAIL single_resp1_quiet: resp1_val was 1 expected 0"); end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_after: busy %b expected 0", bus_if.busy);
        end
    endtask

    task automatic test_simultaneous();
        req_t r0, r1;
        int   n = 0;
        r0 = make_req(3'd0, 8'h11, 32'h0000_0100, '0);
        r1 = make_req(3'd0, 8'h22, 32'h0000_0200, '0);
        do_reset();
        clear_logs();
        src0_q.push_back(r0);
        src1_q.push_back(r1);
        for (int k = 0; k < 60 && (got0.size() + got1.size()) < 2; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_log.size() != 2) begin
            errors++; $display("FAIL simul_count: memory saw %0d requests expected 2", mem_log.size());
        end else begin
            checks++;
            if (mem_log[0][163:132] !== 32'h100 || mem_log[1][163:132] !== 32'h200) begin
                errors++; $display("FAIL simul_mem_order: addrs %h,%h expected 100,200",
                                   mem_log[0][163:132], mem_log[1][163:132]);
            end
        end
        checks++;
        if (resp_order.size() != 2 || resp_order[0] != 0 || resp_order[1] != 1) begin
            errors++; $display("FAIL simul_resp_order: %0d responses, first owner %0d expected 0 then 1",
                               resp_order.size(), (resp_order.size() > 0) ? resp_order[0] : -1);
        end
        checks++;
        if (got0.size() != 1 || got1.size() != 1 || got0[0] !== mem_resp(r0) || got1[0] !== mem_resp(r1)) begin
            errors++; $display("FAIL simul_msgs: got0 n=%0d got1 n=%0d expected one each matching",
                               got0.size(), got1.size());
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_opq;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            src0_q.push_back(make_req(3'd0, 8'h30 + 8'(i), 32'h0000_4000 + 32'(i * 16), '0));
            src1_q.push_back(make_req(3'd1, 8'h40 + 8'(i), 32'h0000_8000 + 32'(i * 16), {4{32'(i)}}));
        end
        for (int k = 0; k < 200 && (got0.size() + got1.size()) < 8; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_log.size() != 8) begin
            errors++; $display("FAIL fair_count: memory saw %0d requests expected 8", mem_log.size());
        end
        for (int k = 0; k < mem_log.size(); k++) begin
            exp_opq = ((k % 2) == 0) ? (8'h30 + 8'(k / 2)) : (8'h40 + 8'(k / 2));
            checks++;
            if (mem_log[k][171:164] !== exp_opq) begin
                errors++; $display("FAIL fair_order[%0d]: opaque %h expected %h", k, mem_log[k][171:164], exp_opq);
            end
        end
        checks++;
        if (got0.size() != 4 || got1.size() != 4) begin
            errors++; $display("FAIL fair_resp_count: got0 %0d got1 %0d expected 4 and 4", got0.size(), got1.size());
        end
    endtask

    task automatic test_backpressure();
        req_t  r0, r1;
        req_t  mr_msg = '0;
        resp_t rs_msg = '0;
        bit    mr_seen = 1'b0, rs_seen = 1'b0, done = 1'b0;
        int    t_acc = -1, send_stall = 0, resp_stall = 0, unstable = 0, busy_drop = 0, extra = 0;
        r1 = make_req(3'd1, 8'h77, 32'hABCD_0040, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        r0 = make_req(3'd0, 8'h78, 32'h0000_0500, '0);
        clear_logs();
        @(negedge clk);
        mreq_stall = 3;
        sink_cnt1  = 5;
        src1_q.push_back(r1);
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (t_acc >= 0) begin
                if (bus_if.busy !== 1'b1) busy_drop++;
                if (bus_if.req0_rdy || bus_if.req1_rdy) extra++;
                if (bus_if.memreq_val) begin
                    if (!mr_seen) mr_msg = bus_if.memreq_msg;
                    else if (bus_if.memreq_msg !== mr_msg) unstable++;
                    mr_seen = 1'b1;
                    if (!bus_if.memreq_rdy) send_stall++;
                end
                if (bus_if.resp1_val) begin
                    if (!rs_seen) rs_msg = bus_if.resp1_msg;
                    else if (bus_if.resp1_msg !== rs_msg) unstable++;
                    rs_seen = 1'b1;
                    if (!bus_if.resp1_rdy) resp_stall++;
                    else done = 1'b1;
                end
            end
            if (t_acc < 0 && bus_if.req1_val && bus_if.req1_rdy) begin
                t_acc = cyc;
                src0_q.push_back(r0);
            end
        end
        for (int k = 0; k < 40 && got0.size() < 1; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (!done) begin errors++; $display("FAIL bp_timeout: no resp1 handshake in 60 cycles"); end
        checks++;
        if (send_stall != 3) begin errors++; $display("FAIL bp_send_stall: %0d cycles expected 3", send_stall); end
        checks++;
        if (resp_stall != 5) begin errors++; $display("FAIL bp_resp_stall: %0d cycles expected 5", resp_stall); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: %0d msg changes expected 0", unstable); end
        checks++;
        if (busy_drop != 0) begin errors++; $display("FAIL bp_busy: %0d busy-low cycles expected 0", busy_drop); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL bp_no_accept: %0d rdy cycles while busy expected 0", extra); end
        checks++;
        if (mr_msg !== r1 || got1.size() != 1 || got1[0] !== mem_resp(r1)) begin
            errors++; $display("FAIL bp_msgs: memreq %h expected %h, got1 n=%0d", mr_msg, r1, got1.size());
        end
        checks++;
        if (got0.size() != 1 || got0[0] !== mem_resp(r0)) begin
            errors++; $display("FAIL bp_held_req: got0 n=%0d expected 1 matching", got0.size());
        end
    endtask

    task automatic test_random();
        resp_t exp0[$];
        resp_t exp1[$];
        req_t  rq;
        logic [2:0]   typ;
        logic [127:0] data;
        clear_logs();
        @(negedge clk);
        mem_rand  = 1'b1;
        sink_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            typ  = 3'($urandom_range(0, 1));
            data = (typ != 3'd0) ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
            rq   = make_req(typ, 8'(i), $urandom, data);
            if ($urandom_range(0, 1) == 0) begin src0_q.push_back(rq); exp0.push_back(mem_resp(rq)); end
            else begin src1_q.push_back(rq); exp1.push_back(mem_resp(rq)); end
        end
        for (int k = 0; k < 20000 && (got0.size() + got1.size()) < 200; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        mem_rand   = 1'b0;
        sink_rand  = 1'b0;
        sink_cnt0  = 0;
        sink_cnt1  = 0;
        mreq_stall = 0;
        checks++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            errors++; $display("FAIL rand_count: got %0d/%0d expected %0d/%0d",
                               got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            checks++;
            if (got0[i] !== exp0[i]) begin
                errors++; $display("FAIL rand_resp0[%0d]: opaque %h expected %h", i, got0[i][141:134], exp0[i][141:134]);
            end
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== exp1[i]) begin
                errors++; $display("FAIL rand_resp1[%0d]: opaque %h expected %h", i, got1[i][141:134], exp1[i][141:134]);
            end
        end
    endtask

    task automatic test_reset_wait();
        req_t       r_a, r_b;
        logic [6:0] obs;
        bit         reached = 1'b0;
        r_a = make_req(3'd0, 8'h66, 32'h0000_3000, '0);
        r_b = make_req(3'd0, 8'h67, 32'h0000_3040, '0);
        clear_logs();
        @(negedge clk);
        mem_lat = 6;
        src0_q.push_back(r_a);
        for (int k = 0; k < 40 && !reached; k++) begin
            @(negedge clk);
            if (bus_if.memresp_rdy) reached = 1'b1;
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL rw_reach_wait: WAIT not seen in 40 cycles"); end
        reset = 1'b0;
        @(negedge clk);
        obs = {bus_if.busy, bus_if.memreq_val, bus_if.memresp_rdy, bus_if.resp0_val,
               bus_if.resp1_val, bus_if.req0_rdy, bus_if.req1_rdy};
        checks++;
        if (obs !== 7'b0) begin errors++; $display("FAIL rw_outputs: got %b expected 0000000", obs); end
        reset   = 1'b1;
        mem_lat = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (got0.size() != 0 || got1.size() != 0 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL rw_discard: got0 %0d got1 %0d busy %b expected 0 0 0",
                               got0.size(), got1.size(), bus_if.busy);
        end
        src0_q.push_back(r_b);
        for (int k = 0; k < 40 && got0.size() < 1; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (got0.size() != 1 || got0[0] !== mem_resp(r_b) || got1.size() != 0) begin
            errors++; $display("FAIL rw_next_req: got0 n=%0d got1 n=%0d expected one matching on 0",
                               got0.size(), got1.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of tests");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
